// File: rtl/i2c_byte_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_byte_ctl_pkg
//  Description : Shared definitions for the I2C byte sequencer: bit-controller
//                command codes, byte FSM state encoding and small helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_byte_ctl_pkg;

    // Bit-controller command codes (shared with i2c_bit_ctl)
    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    // Byte sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } byte_state_t;

    // First state of a new transfer, priority START > READ > WRITE > STOP
    function automatic byte_state_t first_state(input logic start,
                                                input logic read,
                                                input logic write,
                                                input logic stop);
        byte_state_t st;
        st = ST_IDLE;
        if (start)      st = ST_START;
        else if (read)  st = ST_READ;
        else if (write) st = ST_WRITE;
        else if (stop)  st = ST_STOP;
        return st;
    endfunction

    // Bit command issued on entry to a data/framing state
    function automatic logic [3:0] state_cmd(input byte_state_t st);
        logic [3:0] cmd;
        cmd = CMD_NOP;
        case (st)
            ST_START: cmd = CMD_START;
            ST_READ:  cmd = CMD_READ;
            ST_WRITE: cmd = CMD_WRITE;
            ST_STOP:  cmd = CMD_STOP;
            default:  cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_byte_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_byte_ctl
//  Description : Byte-level I2C sequencer. Turns START/WRITE/READ/STOP byte
//                commands into a stream of bit-controller commands, shifts
//                data MSB-first, handles the ACK bit and reports completion,
//                arbitration loss and (optionally) bit-command timeout.
//  Options     : I2C_BYTE_CMD_TIMEOUT_EN - adds a 16-bit bit-command watchdog
//                limited by TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_ctl
    import i2c_byte_ctl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       sysclk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic       ack_in_i,
    input  logic [7:0] din_i,
    output logic       cmd_ack_o,
    output logic       ack_out_o,
    output logic [7:0] dout_o,
    output logic       al_o,
    output logic       timeout_o,
    output logic [3:0] bit_cmd_o,
    input  logic       bit_cmd_ack_i,
    output logic       bit_din_o,
    input  logic       bit_dout_i,
    input  logic       bit_arblost_i
);

    byte_state_t r_state;
    logic [3:0]  r_bit_cmd;
    logic        r_bit_din;
    logic        r_cmd_ack;
    logic        r_al;
    logic        r_timeout;
    logic        r_ack_out;
    logic [7:0]  r_dout;
    logic [7:0]  r_sr;
    logic [2:0]  r_cnt;
    logic        r_rd_byte;   // current byte is a read (selects ACK-phase direction)

    logic        w_any_cmd;
    byte_state_t w_first;
    logic        w_timeout_hit;

    assign w_any_cmd = start_i | read_i | write_i | stop_i;
    assign w_first   = first_state(start_i, read_i, write_i, stop_i);

`ifdef I2C_BYTE_CMD_TIMEOUT_EN
    localparam logic [15:0] c_wdog_limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;

    // An ack arriving on the limit cycle still counts as in time
    assign w_timeout_hit = (r_state != ST_IDLE) && !bit_cmd_ack_i &&
                           (r_wdog == c_wdog_limit);

    // Watchdog: restarts with every newly issued bit command, counts while one is outstanding
    always_ff @(posedge sysclk_i) begin
        if (reset_i || !enable_i || (r_state == ST_IDLE) || bit_cmd_ack_i ||
            bit_arblost_i || w_timeout_hit) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign w_timeout_hit        = 1'b0;
`endif

    // Byte sequencer: one bit command outstanding at a time, advanced on each bit ack
    always_ff @(posedge sysclk_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_bit_cmd <= CMD_NOP;
            r_bit_din <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_al      <= 1'b0;
            r_timeout <= 1'b0;
            r_ack_out <= 1'b0;
            r_dout    <= 8'h00;
            r_sr      <= 8'h00;
            r_cnt     <= 3'd0;
            r_rd_byte <= 1'b0;
        end else begin
            r_cmd_ack <= 1'b0;
            r_al      <= 1'b0;
            r_timeout <= 1'b0;
            if (!enable_i) begin
                // Silent abort: no completion reported
                r_state   <= ST_IDLE;
                r_bit_cmd <= CMD_NOP;
                r_bit_din <= 1'b0;
            end else if ((r_state != ST_IDLE) && bit_arblost_i) begin
                // Arbitration loss only matters while a bit command is in flight
                r_state   <= ST_IDLE;
                r_bit_cmd <= CMD_NOP;
                r_bit_din <= 1'b0;
                r_cmd_ack <= 1'b1;
                r_al      <= 1'b1;
            end else if (w_timeout_hit) begin
                r_state   <= ST_IDLE;
                r_bit_cmd <= CMD_NOP;
                r_bit_din <= 1'b0;
                r_cmd_ack <= 1'b1;
                r_timeout <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_any_cmd) begin
                            r_sr      <= din_i;
                            r_cnt     <= 3'd7;
                            r_state   <= w_first;
                            r_bit_cmd <= state_cmd(w_first);
                            r_bit_din <= (w_first == ST_WRITE) ? din_i[7] : 1'b0;
                            r_rd_byte <= (w_first == ST_READ);
                        end
                    end

                    ST_START: begin
                        if (bit_cmd_ack_i) begin
                            if (read_i) begin
                                r_state   <= ST_READ;
                                r_bit_cmd <= CMD_READ;
                                r_bit_din <= 1'b0;
                                r_rd_byte <= 1'b1;
                            end else if (write_i) begin
                                r_state   <= ST_WRITE;
                                r_bit_cmd <= CMD_WRITE;
                                r_bit_din <= r_sr[7];
                                r_rd_byte <= 1'b0;
                            end else if (stop_i) begin
                                r_state   <= ST_STOP;
                                r_bit_cmd <= CMD_STOP;
                                r_bit_din <= 1'b0;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_bit_cmd <= CMD_NOP;
                                r_bit_din <= 1'b0;
                                r_cmd_ack <= 1'b1;
                            end
                        end
                    end

                    ST_WRITE, ST_READ: begin
                        if (bit_cmd_ack_i) begin
                            r_sr  <= {r_sr[6:0], bit_dout_i};
                            r_cnt <= r_cnt - 3'd1;
                            if (r_cnt == 3'd0) begin
                                r_state <= ST_ACK;
                                if (r_rd_byte) begin
                                    // Master drives ACK/NACK after a read
                                    r_bit_cmd <= CMD_WRITE;
                                    r_bit_din <= ack_in_i;
                                end else begin
                                    // Master samples slave ACK after a write
                                    r_bit_cmd <= CMD_READ;
                                    r_bit_din <= 1'b0;
                                end
                            end else begin
                                // Next data bit to drive is the one about to reach the MSB
                                r_bit_din <= r_rd_byte ? 1'b0 : r_sr[6];
                            end
                        end
                    end

                    ST_ACK: begin
                        if (bit_cmd_ack_i) begin
                            if (r_rd_byte) begin
                                r_dout <= r_sr;
                            end else begin
                                r_ack_out <= bit_dout_i;
                            end
                            r_bit_din <= 1'b0;
                            if (stop_i) begin
                                r_state   <= ST_STOP;
                                r_bit_cmd <= CMD_STOP;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_bit_cmd <= CMD_NOP;
                                r_cmd_ack <= 1'b1;
                            end
                        end
                    end

                    ST_STOP: begin
                        if (bit_cmd_ack_i) begin
                            r_state   <= ST_IDLE;
                            r_bit_cmd <= CMD_NOP;
                            r_bit_din <= 1'b0;
                            r_cmd_ack <= 1'b1;
                        end
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_bit_cmd <= CMD_NOP;
                        r_bit_din <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd_ack_o = r_cmd_ack;
    assign ack_out_o = r_ack_out;
    assign dout_o    = r_dout;
    assign al_o      = r_al;
    assign timeout_o = r_timeout;
    assign bit_cmd_o = r_bit_cmd;
    assign bit_din_o = r_bit_din;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_byte_ctl
//  Description : Directed self-checking bench for i2c_byte_ctl with a simple
//                bit-controller model that acks with fixed latency.
//  Options     : I2C_BYTE_CMD_TIMEOUT_EN - selects the timeout expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_ctl;

    localparam logic [3:0] C_NOP   = 4'b0000;
    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_STOP  = 4'b0010;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_READ  = 4'b1000;
    localparam int         M_LAT   = 4;

    logic       sysclk_i = 1'b0;
    logic       reset_i, enable_i, start_i, stop_i, read_i, write_i, ack_in_i;
    logic [7:0] din_i;
    logic       cmd_ack_o, ack_out_o, al_o, timeout_o, bit_din_o;
    logic [7:0] dout_o;
    logic [3:0] bit_cmd_o;
    logic       bit_cmd_ack_i, bit_dout_i, bit_arblost_i;

    // Model / log state
    logic       m_on;
    int         m_arb_at;
    int         m_cnt;
    logic [7:0] m_rd_bits;
    logic [3:0] log_cmd [0:31];
    logic       log_din [0:31];
    int         log_n;
    int         ack_cnt, al_cnt, to_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 sysclk_i = ~sysclk_i;

    i2c_byte_ctl #(.TIMEOUT_CYCLES(20)) dut (
        .sysclk_i      (sysclk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .read_i        (read_i),
        .write_i       (write_i),
        .ack_in_i      (ack_in_i),
        .din_i         (din_i),
        .cmd_ack_o     (cmd_ack_o),
        .ack_out_o     (ack_out_o),
        .dout_o        (dout_o),
        .al_o          (al_o),
        .timeout_o     (timeout_o),
        .bit_cmd_o     (bit_cmd_o),
        .bit_cmd_ack_i (bit_cmd_ack_i),
        .bit_din_o     (bit_din_o),
        .bit_dout_i    (bit_dout_i),
        .bit_arblost_i (bit_arblost_i)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-controller model: acks each outstanding command M_LAT cycles after issue
    always @(negedge sysclk_i) begin
        if (bit_cmd_ack_i || bit_arblost_i) begin
            bit_cmd_ack_i = 1'b0;
            bit_arblost_i = 1'b0;
            m_cnt         = 0;
        end else if (m_on && !reset_i && bit_cmd_o != C_NOP) begin
            m_cnt++;
            if (m_cnt == M_LAT) begin
                m_cnt = 0;
                if (bit_cmd_o == C_WRITE) begin
                    bit_dout_i = bit_din_o;
                end else if (bit_cmd_o == C_READ) begin
                    bit_dout_i = m_rd_bits[7];
                    m_rd_bits  = {m_rd_bits[6:0], 1'b0};
                end else begin
                    bit_dout_i = 1'b0;
                end
                if (log_n < 32) begin
                    log_cmd[log_n] = bit_cmd_o;
                    log_din[log_n] = bit_din_o;
                end
                if (log_n == m_arb_at) bit_arblost_i = 1'b1;
                log_n++;
                bit_cmd_ack_i = 1'b1;
            end
        end else begin
            m_cnt = 0;
        end
    end

    // Pulse counters
    always @(negedge sysclk_i) begin
        if (cmd_ack_o) ack_cnt++;
        if (al_o)      al_cnt++;
        if (timeout_o) to_cnt++;
    end

    task automatic wait_cmd_ack(input string tag);
        int k;
        k = 0;
        while (cmd_ack_o !== 1'b1 && k < 300) begin
            @(negedge sysclk_i);
            k++;
        end
        if (cmd_ack_o !== 1'b1) check_val({tag, " cmd_ack wait"}, 32'd0, 32'd1);
    endtask

    task automatic clear_cmds();
        start_i = 1'b0;
        stop_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a5;
        int         ack0, al0, to0, k;

        reset_i = 1'b1; enable_i = 1'b1; ack_in_i = 1'b0; din_i = 8'h00;
        clear_cmds();
        bit_cmd_ack_i = 1'b0; bit_dout_i = 1'b0; bit_arblost_i = 1'b0;
        m_on = 1'b1; m_arb_at = -1; m_cnt = 0; m_rd_bits = 8'h00;
        log_n = 0; ack_cnt = 0; al_cnt = 0; to_cnt = 0;

        // ---- reset state
        repeat (3) @(negedge sysclk_i);
        check_val("rst bit_cmd", bit_cmd_o, C_NOP);
        check_val("rst bit_din", bit_din_o, 0);
        check_val("rst cmd_ack", cmd_ack_o, 0);
        check_val("rst al",      al_o, 0);
        check_val("rst timeout", timeout_o, 0);
        check_val("rst ack_out", ack_out_o, 0);
        check_val("rst dout",    dout_o, 8'h00);
        reset_i = 1'b0;
        @(negedge sysclk_i);

        // ---- start+write 0xA5, slave ACK=0
        ack0 = ack_cnt; log_n = 0; m_rd_bits = 8'h00;
        din_i = 8'hA5; start_i = 1'b1; write_i = 1'b1;
        wait_cmd_ack("wr");
        clear_cmds();
        repeat (3) @(negedge sysclk_i);
        exp_a5 = 8'b1010_0101;
        check_val("wr n",       log_n, 10);
        check_val("wr cmd0",    log_cmd[0], C_START);
        for (int i = 1; i <= 8; i++) begin
            check_val($sformatf("wr cmd%0d", i), log_cmd[i], C_WRITE);
            check_val($sformatf("wr bit%0d", i), log_din[i], exp_a5[8-i]);
        end
        check_val("wr cmd9",    log_cmd[9], C_READ);
        check_val("wr ack_out", ack_out_o, 0);
        check_val("wr acks",    ack_cnt - ack0, 1);
        check_val("wr idle",    bit_cmd_o, C_NOP);

        // ---- read+stop, master NACK, slave bits 0x3C
        ack0 = ack_cnt; log_n = 0; m_rd_bits = 8'h3C;
        ack_in_i = 1'b1; read_i = 1'b1; stop_i = 1'b1;
        wait_cmd_ack("rd");
        check_val("rd n at ack", log_n, 10);
        clear_cmds();
        repeat (3) @(negedge sysclk_i);
        for (int i = 0; i < 8; i++) check_val($sformatf("rd cmd%0d", i), log_cmd[i], C_READ);
        check_val("rd ack cmd", log_cmd[8], C_WRITE);
        check_val("rd ack bit", log_din[8], 1);
        check_val("rd stop",    log_cmd[9], C_STOP);
        check_val("rd dout",    dout_o, 8'h3C);
        check_val("rd acks",    ack_cnt - ack0, 1);

        // ---- arbitration lost on 5th write bit (with its ack)
        ack0 = ack_cnt; al0 = al_cnt; log_n = 0; m_arb_at = 4;
        din_i = 8'h5A; write_i = 1'b1;
        wait_cmd_ack("al");
        clear_cmds();
        check_val("al al_o",    al_o, 1);
        check_val("al bit_cmd", bit_cmd_o, C_NOP);
        check_val("al dout",    dout_o, 8'h3C);
        check_val("al ack_out", ack_out_o, 0);
        @(negedge sysclk_i);
        check_val("al pulse",   al_o, 0);
        check_val("al ackpls",  cmd_ack_o, 0);
        repeat (3) @(negedge sysclk_i);
        m_arb_at = -1;
        check_val("al n",       log_n, 5);
        check_val("al acks",    ack_cnt - ack0, 1);
        check_val("al cnt",     al_cnt - al0, 1);

        // ---- reset mid-read
        ack0 = ack_cnt; log_n = 0; m_rd_bits = 8'hC3; read_i = 1'b1;
        k = 0;
        while (log_n < 3 && k < 100) begin
            @(negedge sysclk_i);
            k++;
        end
        check_val("mr reached bit3", (log_n >= 3), 1);
        reset_i = 1'b1;
        clear_cmds();
        @(negedge sysclk_i);
        check_val("mr bit_cmd", bit_cmd_o, C_NOP);
        check_val("mr dout",    dout_o, 8'h00);
        check_val("mr bit_din", bit_din_o, 0);
        check_val("mr cmd_ack", cmd_ack_o, 0);
        reset_i = 1'b0;
        repeat (2) @(negedge sysclk_i);
        check_val("mr no ack",  ack_cnt - ack0, 0);
        // write 0xFF after reset, slave NACKs
        ack0 = ack_cnt; log_n = 0; m_rd_bits = 8'h80;
        din_i = 8'hFF; write_i = 1'b1;
        wait_cmd_ack("ff");
        clear_cmds();
        repeat (3) @(negedge sysclk_i);
        check_val("ff n", log_n, 9);
        for (int i = 0; i < 8; i++) check_val($sformatf("ff bit%0d", i), log_din[i], 1);
        check_val("ff ack cmd", log_cmd[8], C_READ);
        check_val("ff ack_out", ack_out_o, 1);
        check_val("ff acks",    ack_cnt - ack0, 1);

        // ---- enable low with write held
        ack0 = ack_cnt; log_n = 0; m_rd_bits = 8'h00;
        enable_i = 1'b0; din_i = 8'h00; write_i = 1'b1;
        repeat (10) @(negedge sysclk_i);
        check_val("en hold cmd", bit_cmd_o, C_NOP);
        check_val("en no ack",   ack_cnt - ack0, 0);
        enable_i = 1'b1;
        @(negedge sysclk_i);
        check_val("en start",    bit_cmd_o, C_WRITE);
        wait_cmd_ack("en");
        clear_cmds();
        repeat (3) @(negedge sysclk_i);
        check_val("en n",        log_n, 9);
        check_val("en ack_out",  ack_out_o, 0);
        check_val("en acks",     ack_cnt - ack0, 1);

        // ---- bit controller never acks
        m_on = 1'b0; ack0 = ack_cnt; to0 = to_cnt;
        write_i = 1'b1;
        @(negedge sysclk_i);
        check_val("to issued", bit_cmd_o, C_WRITE);
`ifdef I2C_BYTE_CMD_TIMEOUT_EN
        k = 0;
        while (timeout_o !== 1'b1 && k < 100) begin
            @(negedge sysclk_i);
            k++;
        end
        check_val("to latency", k, 20);
        check_val("to cmd_ack", cmd_ack_o, 1);
        clear_cmds();
        @(negedge sysclk_i);
        check_val("to pulse",   timeout_o, 0);
        check_val("to nop",     bit_cmd_o, C_NOP);
        check_val("to count",   to_cnt - to0, 1);
`else
        repeat (1000) @(negedge sysclk_i);
        check_val("to none",    to_cnt - to0, 0);
        check_val("to no ack",  ack_cnt - ack0, 0);
        check_val("to held",    bit_cmd_o, C_WRITE);
        enable_i = 1'b0;
        clear_cmds();
        @(negedge sysclk_i);
        check_val("to abort",   bit_cmd_o, C_NOP);
        repeat (2) @(negedge sysclk_i);
        check_val("to abort ack", ack_cnt - ack0, 0);
        enable_i = 1'b1;
`endif
        m_on = 1'b1;
        repeat (2) @(negedge sysclk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_byte_ctl.md
Name: i2c_byte_ctl

Overview:
- Byte-level I2C sequencer sitting directly upstream of the bit controller; driven by the core's command/control register logic.
- Converts byte commands (START, WRITE, READ, STOP) into the bit controller's 4-bit command stream, one bit command per bit-controller ack.
- Shifts 8 data bits MSB-first, handles the ACK/NACK bit and reports byte completion and arbitration loss upstream.

Parameters:
- TIMEOUT_CYCLES, 65535: maximum sysclk_i cycles between issuing a bit command and its ack; used only when the optional feature is compiled in.

Ports:
- sysclk_i  in  1  system clock
- reset_i  in  1  reset; one clock; synchronous, active-high
- enable_i  in  1  core enable; low forces IDLE
- start_i  in  1  generate (repeated) START before the byte
- stop_i  in  1  generate STOP after the byte (or alone)
- read_i  in  1  read one byte
- write_i  in  1  write one byte
- ack_in_i  in  1  ACK bit to send after a read (0=ACK, 1=NACK)
- din_i  in  8  byte to transmit
- cmd_ack_o  out  1  one-cycle pulse: byte command complete or aborted
- ack_out_o  out  1  ACK received from slave after a write (0=ACK)
- dout_o  out  8  received byte
- al_o  out  1  one-cycle pulse: arbitration lost
- timeout_o  out  1  one-cycle pulse: bit-command timeout (tied 0 without feature)
- bit_cmd_o  out  4  command to bit controller
- bit_cmd_ack_i  in  1  bit controller command-complete pulse
- bit_din_o  out  1  bit to drive (bit controller's bit_i)
- bit_dout_i  in  1  bit sampled by bit controller (its bit_o)
- bit_arblost_i  in  1  arbitration lost from bit controller

Behaviour:
- Reset: state IDLE; bit_cmd_o=CMD_NOP; bit_din_o=0; cmd_ack_o=0; al_o=0; timeout_o=0; ack_out_o=0; dout_o=0x00; shift reg and bit counter 0.
- FSM states: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE: when enable_i=1 and any of start/read/write/stop is high, the next edge loads shift reg <= din_i, bit counter <= 7, and enters the first applicable state. Priority: START > READ > WRITE > STOP. bit_cmd_o is set with the state: START->CMD_START, READ->CMD_READ, WRITE->CMD_WRITE, STOP->CMD_STOP.
- Command hold: bit_cmd_o stays constant until bit_cmd_ack_i is sampled high. On that edge the FSM advances and bit_cmd_o takes the next state's command.
- START ack: go to READ if read_i, else WRITE if write_i, else STOP if stop_i, else IDLE with cmd_ack_o pulse.
- WRITE: bit_din_o = shift reg[7].
- WRITE/READ ack: shift reg <= {sr[6:0], bit_dout_i}; counter decrements. Counter==0 at ack -> ACK state.
- ACK, after write: issue CMD_READ; on ack, ack_out_o <= bit_dout_i.
- ACK, after read: issue CMD_WRITE with bit_din_o = ack_in_i; on ack, dout_o <= shift reg.
- ACK ack: if stop_i -> STOP, else IDLE with cmd_ack_o pulse.
- STOP ack: IDLE with cmd_ack_o pulse.
- cmd_ack_o is exactly one cycle. Upstream clears its command bits on it. Commands still high in the cycle after cmd_ack_o start a new transfer.
- bit_arblost_i=1 in any state overrides a simultaneous bit_cmd_ack_i. Next edge: IDLE, bit_cmd_o=CMD_NOP, cmd_ack_o and al_o pulse together for one cycle. dout_o and ack_out_o are unchanged.
- enable_i=0: next edge forces IDLE and CMD_NOP with no cmd_ack_o; commands are ignored.
- reset_i mid-byte: all reset values next edge, outstanding command dropped.
- Commands arriving outside IDLE are not re-sampled except at the decision points above (inputs must be held stable by upstream until cmd_ack_o).

Optional Feature:
- Macro: I2C_BYTE_CMD_TIMEOUT_EN.
- Defined: a 16-bit watchdog clears whenever bit_cmd_o changes or in IDLE, and increments while a command is outstanding. On reaching TIMEOUT_CYCLES: IDLE, CMD_NOP, cmd_ack_o and timeout_o pulse one cycle. Arblost has priority over timeout in the same cycle.
- Undefined: no counter; timeout_o tied 0; TIMEOUT_CYCLES unused.

Decomposition:
- Shared include/package i2c-def.v holds:
  - CMD_NOP=4'b0000, CMD_START=4'b0001, CMD_STOP=4'b0010, CMD_WRITE=4'b0100, CMD_READ=4'b1000, shared with i2c_bit_ctl.
  - FSM state encodings.
- No sub-module; optional i2c_bit_model (bench only) emulates bit-controller acks with a fixed latency.

Test Plan:
- start+write, din=0xA5, model acks every 4 cycles, slave returns ACK=0 -> bit_cmd_o sequence START, WRITE x8, READ; bit_din_o 1,0,1,0,0,1,0,1; ack_out_o=0; single cmd_ack_o.
- read+stop, ack_in=1, model bits 0x3C -> READ x8, WRITE(bit_din_o=1), STOP; dout_o=0x3C; one cmd_ack_o after STOP ack.
- bit_arblost_i on 5th WRITE bit, same cycle as bit_cmd_ack_i -> next cycle IDLE, CMD_NOP, al_o and cmd_ack_o one-cycle, dout_o unchanged.
- reset_i during READ bit 3 -> next edge all outputs at reset values; a subsequent write 0xFF completes normally.
- enable_i=0 with write_i held -> bit_cmd_o stays CMD_NOP, no cmd_ack_o; enable_i=1 -> transfer starts next edge.
- With I2C_BYTE_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=20, model never acks -> timeout_o and cmd_ack_o pulse 20 cycles after CMD_WRITE issued; without the macro, no pulse within 1000 cycles.
